// File: rtl/pulse_sync_arbiter_pkg.sv
// Shared types for the pulse synchronizer front-end scheduler.
// Code width, issue FSM states and the requester eligibility rule.
package pulse_sync_arb_pkg;

  localparam int CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DRAIN
  } state_t;

  // Code 0 means "no pulse", so it never competes for the crossing.
  function automatic logic code_eligible(input logic valid, input code_t code);
    return valid && (code != '0);
  endfunction

endpackage

// File: rtl/pulse_sync_arbiter_if.sv
// Requester handshake plus the link to the pulse synchronizer.
// The master side drives requests and busy; the slave side is the scheduler.
interface pulse_sync_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]                            req_valid;
  logic [pulse_sync_arb_pkg::CODE_W*N_REQ-1:0] req_code;
  logic [N_REQ-1:0]                            req_ready;
  logic                                        sync_busy;
  logic [pulse_sync_arb_pkg::CODE_W-1:0]       sync_sig;

  modport master (
    output req_valid, req_code, sync_busy,
    input  req_ready, sync_sig
  );

  modport slave (
    input  req_valid, req_code, sync_busy,
    output req_ready, sync_sig
  );
endinterface

// File: rtl/sync_req_fifo.sv
// Small synchronous FIFO with first-word fall-through read.
// Simultaneous push and pop are legal at any level, including full.
module sync_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = level_reg;
  // The popped word must be available in the pop cycle itself.
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end
endmodule

// File: rtl/pulse_sync_arbiter.sv
// Round-robin scheduler feeding one pulse synchronizer: requests queue in a
// FIFO and the issue FSM sends one single-cycle pulse per busy handshake.
module pulse_sync_arbiter
  import pulse_sync_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DEPTH   = 4,
  parameter int BUSY_TO = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  pulse_sync_arbiter_if.slave        bus,
  input  logic                       err_clr,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       idle,
  output logic                       err_timeout
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TO+1);

  code_t              codes [N_REQ];
  logic [N_REQ-1:0]   eligible;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  int                 cand;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  code_t              fifo_rdata;
  state_t             state_reg;
  code_t              sig_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               err_reg;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign codes[gi]         = bus.req_code[gi*CODE_W +: CODE_W];
      assign eligible[gi]      = code_eligible(bus.req_valid[gi], codes[gi]);
      assign bus.req_ready[gi] = push && (win_idx == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && eligible[PTR_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  // A full FIFO still accepts when the issue FSM pops in the same cycle.
  assign pop  = (state_reg == IDLE) && !fifo_empty && !bus.sync_busy;
  assign push = win_found && (!fifo_full || pop);

  sync_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (codes[win_idx]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
    end else if (push) begin
      rr_ptr_reg <= (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Later assignment to err_reg overrides err_clr, so a timeout set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      sig_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      sig_reg <= '0;
      if (err_clr) err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            sig_reg   <= fifo_rdata;
            cnt_reg   <= CNT_W'(1);
            state_reg <= ARM;
          end
        end
        ARM: begin
          if (bus.sync_busy) begin
            state_reg <= DRAIN;
          end else if (cnt_reg == CNT_W'(BUSY_TO)) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (!bus.sync_busy) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.sync_sig = sig_reg;
  assign err_timeout  = err_reg;
  assign idle         = fifo_empty && (state_reg == IDLE) && !bus.sync_busy;
endmodule

// File: tb/tb_pulse_sync_arbiter.sv
// Self-checking bench: vector tables, directed corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_pulse_sync_arbiter;
  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int BUSY_TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_clr;
  logic [2:0] fifo_level;
  logic       idle;
  logic       err_timeout;

  always #5 clk = ~clk;

  pulse_sync_arbiter_if #(.N_REQ(N)) bus();

  pulse_sync_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .BUSY_TO(BUSY_TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .err_clr     (err_clr),
    .fifo_level  (fifo_level),
    .idle        (idle),
    .err_timeout (err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending codes in a queue, in-flight pulse tracked by the
  // cycle it appeared and whether busy has been seen since.
  int q[$];
  int m_rr, m_t0, m_sig, m_cyc;
  bit m_fly, m_seen, m_err;

  // Outputs sampled in the most recent cycle.
  int s_ready, s_sig, s_lvl, s_idle, s_err;

  typedef struct {
    logic [3:0]  v;
    logic [11:0] codes;
    logic        busy;
    logic [3:0]  ready;
    int          sig;
    int          lvl;
    logic        idl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] v, logic [11:0] c, logic b,
                              logic [3:0] r, int s, int l, logic i);
    vec_t t;
    t.v = v; t.codes = c; t.busy = b; t.ready = r; t.sig = s; t.lvl = l; t.idl = i;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rr = 0; m_sig = 0; m_fly = 0; m_seen = 0; m_err = 0; m_t0 = 0;
  endtask

  // Called at a negedge: drive, sample, check, advance model, move to next negedge.
  task automatic cycle(input logic [3:0] v, input logic [11:0] codes,
                       input logic busy, input logic clr, input bit use_model);
    int win, idx, el, e_rdy, e_idle, cd;
    bit pop_now, grant, set_err;
    bus.req_valid = v;
    bus.req_code  = codes;
    bus.sync_busy = busy;
    err_clr       = clr;
    #1;
    s_ready = int'(bus.req_ready);
    s_sig   = int'(bus.sync_sig);
    s_lvl   = int'(fifo_level);
    s_idle  = int'(idle);
    s_err   = int'(err_timeout);

    e_idle  = (q.size() == 0 && !m_fly && !busy) ? 1 : 0;
    pop_now = !m_fly && q.size() > 0 && !busy;
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      cd  = int'((codes >> (3*idx)) & 12'h7);
      if (win < 0 && ((v >> idx) & 4'h1) != 0 && cd != 0) win = idx;
    end
    grant = (win >= 0) && (q.size() < DEPTH || pop_now);
    e_rdy = grant ? (1 << win) : 0;

    if (use_model) begin
      chk("m_ready", s_ready, e_rdy);
      chk("m_sig",   s_sig,   m_sig);
      chk("m_level", s_lvl,   q.size());
      chk("m_idle",  s_idle,  e_idle);
      chk("m_err",   s_err,   int'(m_err));
    end
    if (s_sig != 0) $display("cycle %0d: pulse code %0d issued, level %0d", m_cyc, s_sig, s_lvl);

    set_err = 0;
    if (m_fly) begin
      el = m_cyc - m_t0 + 1;
      if (!m_seen) begin
        if (busy) m_seen = 1;
        else if (el == BUSY_TO) begin set_err = 1; m_fly = 0; end
      end else if (!busy) begin
        m_fly = 0;
      end
    end
    m_sig = 0;
    if (pop_now) begin
      m_sig  = q.pop_front();
      m_fly  = 1;
      m_seen = 0;
      m_t0   = m_cyc + 1;
    end
    if (grant) begin
      q.push_back(int'((codes >> (3*win)) & 12'h7));
      m_rr = (win + 1) % N;
    end
    if (clr) m_err = 0;
    if (set_err) m_err = 1;
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b0;
    bus.req_valid = '0;
    err_clr = 1'b0;
    #1;
    chk("rst_sig",   int'(bus.sync_sig), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_err",   int'(err_timeout), 0);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_idle",  int'(idle), bus.sync_busy ? 0 : 1);
    repeat (hold) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic settle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 120 && !ok; k++) begin
      cycle(4'b0, 12'b0, 1'b0, 1'b1, 1);
      if (s_idle == 1 && s_err == 0) ok = 1;
    end
    chk("settle", int'(ok), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  pend;
    logic [11:0] pk;
    logic [2:0]  pc [4];
    int first, busy_delay, busy_left;
    logic busy_now, clr;

    bus.req_valid = '0; bus.req_code = '0; bus.sync_busy = 1'b0;
    err_clr = 1'b0; rst = 1'b0;
    model_reset();
    m_cyc = 0;
    @(negedge clk);
    do_reset(1);

    // Round-robin with codes 1..4 from rr_ptr=0, then a single request.
    tbl.push_back(mk(4'b1111, 12'b100_011_010_001, 0, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(4'b1110, 12'b100_011_010_001, 0, 4'b0010, 0, 1, 0));
    tbl.push_back(mk(4'b1100, 12'b100_011_010_001, 0, 4'b0100, 1, 1, 0));
    tbl.push_back(mk(4'b1000, 12'b100_011_010_001, 1, 4'b1000, 0, 2, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 1, 4'b0, 0, 3, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 0, 4'b0, 0, 3, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 0, 4'b0, 0, 3, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 1, 4'b0, 2, 2, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 0, 4'b0, 0, 2, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 0, 4'b0, 0, 2, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 1, 4'b0, 3, 1, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 0, 4'b0, 0, 1, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 0, 4'b0, 0, 1, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 1, 4'b0, 4, 0, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 0, 4'b0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 12'b0, 0, 4'b0, 0, 0, 1));
    tbl.push_back(mk(4'b0001, 12'd6, 0, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 12'd0, 0, 4'b0, 0, 1, 0));
    tbl.push_back(mk(4'b0000, 12'd0, 0, 4'b0, 6, 0, 0));
    tbl.push_back(mk(4'b0000, 12'd0, 1, 4'b0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 12'd0, 1, 4'b0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 12'd0, 0, 4'b0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 12'd0, 0, 4'b0, 0, 0, 1));

    foreach (tbl[r]) begin
      cycle(tbl[r].v, tbl[r].codes, tbl[r].busy, 1'b0, 0);
      $display("vec %0d: ready=%b sig=%0d level=%0d idle=%0d", r, s_ready[3:0], s_sig, s_lvl, s_idle);
      chk("tbl_ready", s_ready, int'(tbl[r].ready));
      chk("tbl_sig",   s_sig,   tbl[r].sig);
      chk("tbl_level", s_lvl,   tbl[r].lvl);
      chk("tbl_idle",  s_idle,  int'(tbl[r].idl));
      chk("tbl_err",   s_err,   0);
    end

    // Timeout: busy never rises; second pulse follows; clear, then clear vs set.
    for (int k = 0; k <= 20; k++) begin
      pend = (k == 0) ? 4'b0010 : (k == 1) ? 4'b0100 : 4'b0000;
      clr  = (k == 12 || k == 18);
      cycle(pend, 12'b000_111_101_000, 1'b0, clr, 1);
      if (k == 2)  chk("to_pulse", s_sig, 5);
      if (k == 3)  chk("to_pulse_width", s_sig, 0);
      if (k == 9)  chk("to_err_early", s_err, 0);
      if (k == 10) chk("to_err_set", s_err, 1);
      if (k == 11) chk("to_next_pulse", s_sig, 7);
      if (k == 13) chk("to_err_clr", s_err, 0);
      if (k == 19) chk("to_set_wins", s_err, 1);
    end
    settle();

    // FIFO full with busy held high; fifth request granted in the pop cycle.
    pend = 4'b1111;
    first = -1;
    for (int k = 0; k < 4; k++) begin
      cycle(pend, 12'b100_011_010_001, 1'b1, 1'b0, 1);
      chk("full_onehot", $countones(s_ready), 1);
      if (k == 0) for (int i = 0; i < N; i++) if (((s_ready >> i) & 1) != 0) first = i;
      pend = pend & ~s_ready[3:0];
    end
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0001, 12'b100_011_010_111, 1'b1, 1'b0, 1);
      chk("full_level", s_lvl, 4);
      chk("full_block", s_ready, 0);
    end
    cycle(4'b0001, 12'b100_011_010_111, 1'b0, 1'b0, 1);
    chk("full_pop_grant", s_ready, 1);
    chk("full_pop_level", s_lvl, 4);
    cycle(4'b0000, 12'b0, 1'b0, 1'b0, 1);
    chk("full_after_level", s_lvl, 4);
    chk("full_first_sig", s_sig, first + 1);
    settle();

    // Code 0 never granted; reset in DRAIN with three entries queued.
    cycle(4'b0001, 12'd5, 1'b0, 1'b0, 1);
    cycle(4'b0000, 12'd0, 1'b0, 1'b0, 1);
    cycle(4'b0000, 12'd0, 1'b1, 1'b0, 1);
    chk("rd_pulse", s_sig, 5);
    pend = 4'b1111;
    for (int k = 3; k <= 7; k++) begin
      cycle(pend, 12'b000_011_010_001, 1'b1, 1'b0, 1);
      chk("code0_block", (s_ready >> 3) & 1, 0);
      if (k >= 6) chk("rd_level", s_lvl, 3);
      pend = pend & ~s_ready[3:0];
    end
    do_reset(2);
    cycle(4'b0010, 12'b000_000_110_000, 1'b1, 1'b0, 1);
    chk("post_rst_grant", s_ready, 2);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, 12'd0, 1'b1, 1'b0, 1);
      chk("post_rst_hold_sig", s_sig, 0);
      chk("post_rst_hold_lvl", s_lvl, 1);
    end
    cycle(4'b0000, 12'd0, 1'b0, 1'b0, 1);
    cycle(4'b0000, 12'd0, 1'b0, 1'b0, 1);
    chk("post_rst_pulse", s_sig, 6);
    settle();

    // Randomized traffic with an emulated synchronizer busy response.
    pend = '0; busy_delay = 0; busy_left = 0;
    for (int i = 0; i < N; i++) pc[i] = '0;
    for (int r = 0; r < 600; r++) begin
      if (r == 300) do_reset(2);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 35) begin
          pend[i] = 1'b1;
          pc[i] = 3'($urandom_range(0, 7));
        end else if (pend[i] && pc[i] == 3'd0 && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b0;
        end
      end
      pk = '0;
      for (int i = 0; i < N; i++) pk = pk | (12'(pc[i]) << (3*i));
      busy_now = 1'b0;
      if (busy_left > 0) begin
        busy_now = 1'b1;
        busy_left--;
      end else if (busy_delay > 0) begin
        busy_delay--;
        if (busy_delay == 0) begin
          busy_now = 1'b1;
          busy_left = $urandom_range(0, 4);
        end
      end
      clr = ($urandom_range(0, 9) == 0);
      cycle(pend, pk, busy_now, clr, 1);
      pend = pend & ~s_ready[3:0];
      if (s_sig != 0) busy_delay = $urandom_range(1, 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pulse_sync_arbiter.md
# pulse_sync_arbiter

Fast-domain scheduler that shares one `pulse_sync_3bit` crossing between several requesters. Requesters post 3-bit event codes, which are buffered in a small FIFO. A round-robin arbiter chooses which requester enqueues each cycle. An issue FSM sends one single-cycle pulse at a time into the synchronizer and does not send the next until the synchronizer's `busy` handshake completes. The block sits entirely in the `clk_a` domain, in front of `pulse_sync_3bit`.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `BUSY_TO`, 8: maximum cycles allowed for `sync_busy` to rise after a pulse.
- `clk` in 1: fast clock (same clock as synchronizer `clk_a`).
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_code` in 3*N_REQ: flattened codes; requester i uses bits [3i+2:3i].
- `req_ready` out N_REQ: one-hot grant; a request is accepted in any cycle where `valid & ready`.
- `sync_busy` in 1: connected to the synchronizer's `busy`.
- `sync_sig` out 3: connected to the synchronizer's `sig_3bit`.
- `fifo_level` out $clog2(DEPTH+1): current FIFO occupancy.
- `idle` out 1: high when the FIFO is empty, the FSM is in IDLE and `sync_busy` is low.
- `err_timeout` out 1: sticky flag; `sync_busy` failed to rise within `BUSY_TO`.
- `err_clr` in 1: synchronous clear of `err_timeout`.

## Operation
- **Eligibility:** requester i is eligible when `req_valid[i]` is high and its code is nonzero. Code 0 means "no pulse" and is never granted.
- **Arbitration:** round-robin, searching from `rr_ptr` upward with wrap.
  - The winner w is granted only if `fifo_level < DEPTH`, or if the FIFO is full and a pop occurs in the same cycle.
  - On a grant, `rr_ptr <= (w+1) mod N_REQ`. With no grant, `rr_ptr` holds.
  - `req_ready` is combinational from valid, level and pop.
  - Requesters hold `valid` and `code` stable until granted.
- **FIFO:** 3-bit entries. Push and pop in the same cycle are allowed at any level, including full; level is unchanged in that case.
- **FSM states:**
  - IDLE: when the FIFO is non-empty and `sync_busy` is low, pop one entry, load it into the `sync_sig` register and go to ARM. Otherwise stay.
  - ARM: `sync_sig` is held at 0 from the second ARM cycle onward. A cycle counter starts at 1.
    - If `sync_busy` is high, go to DRAIN.
    - Otherwise, if the counter equals `BUSY_TO`, set `err_timeout` and go to IDLE.
  - DRAIN: go to IDLE when `sync_busy` is low.
- **Error flag:** `err_clr` clears `err_timeout`. If a set and a clear occur in the same cycle, the set wins.

## Timing
- **Reset values:** `sync_sig`=0, `req_ready`=0, `fifo_level`=0, `err_timeout`=0, `rr_ptr`=0, FSM=IDLE. `idle` follows `sync_busy` after reset.
- **Acceptance to pulse:** a request accepted in cycle t with the FIFO empty and the FSM idle produces `sync_sig`=code in cycle t+2. The value is held for exactly one cycle and is 0 in cycle t+3.
- **Pulse shape:** `sync_sig` is registered and is never nonzero for two consecutive cycles.
- **Back-to-back issue:** a new pulse is issued no earlier than 2 cycles after `sync_busy` falls in DRAIN (one cycle to enter IDLE, one registered issue).
- **Timeout:** if `sync_busy` never rises, `err_timeout` is set at the end of ARM counter value `BUSY_TO`, i.e. in cycle t+2+`BUSY_TO` relative to the example above. The next entry may then be issued.
- **Reset mid-operation:** the FIFO is flushed and pending entries are lost. A pulse already inside the synchronizer completes on its own. After reset release, IDLE does not issue while the synchronizer is still busy.
- **Simultaneous events:** a request arriving while the FIFO is full and a pop occurs is granted in that same cycle. `err_clr` together with a timeout leaves the flag set.

## Structure
- **Package `pulse_sync_arb_pkg`:** `CODE_W`=3, state enum `{IDLE, ARM, DRAIN}`, and a `code_t` typedef.
- **Sub-module `sync_req_fifo`:** synchronous FIFO, parameterised by DEPTH and width, with push, pop, level, full and empty. It uses the same clock and the same asynchronous active-low reset.
- **Top level:** the arbiter, FSM, timeout counter and error flag are in the top module.

## Test plan
- **Single request:** `req_valid[0]`=1 with code 6. `req_ready[0]`=1 in that cycle. `sync_sig`=6 for one cycle two cycles later. Drive `busy` high then low; `idle` returns high.
- **Round-robin order:** all four requesters valid with codes 1,2,3,4 and `rr_ptr`=0. Grants occur in order 0,1,2,3 over 4 consecutive cycles. `sync_sig` sequence is 1,2,3,4, each pulse issued only after the previous `busy` falls.
- **FIFO full:** hold `sync_busy` high and post 5 requests. Four are accepted and `fifo_level`=4. The fifth requester's `req_ready` stays 0 until `busy` drops and a pop occurs; it is granted in the pop cycle.
- **Timeout:** `busy` never asserts, `BUSY_TO`=8. `err_timeout` rises 8 cycles after the pulse and the next entry is issued. Pulsing `err_clr` clears the flag.
- **Code 0 and reset:** a code-0 request is never granted. Assert `rst` during DRAIN with 3 entries queued: all outputs go to 0 and the level to 0. After release, with `busy` still high, no pulse is issued until `busy` falls.
